// File: rtl/axi_ic_pkg.sv
// Shared definitions for the AXI interconnect: width helpers, B-grant FSM
// state type and response/ID channel widths.
package axi_ic_pkg;

  localparam int BRESP_W = 2;
  localparam int ID_W    = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } b_grant_state_e;

  // A select index is never narrower than one bit, even for a single slave.
  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr_i,
// wrapping, so the slave at ptr_i itself has lowest priority.
module rr_pick
  import axi_ic_pkg::*;
#(
  parameter  int Width = 2,
  localparam int SelW  = sel_width(Width)
) (
  input  logic [Width-1:0] req_i,
  input  logic [SelW-1:0]  ptr_i,
  output logic [Width-1:0] grant_o,
  output logic [SelW-1:0]  bin_grant_o,
  output logic             any_o
);

  always_comb begin
    int idx;
    grant_o     = '0;
    bin_grant_o = '0;
    any_o       = 1'b0;
    idx         = 0;
    for (int k = 1; k <= Width; k++) begin
      idx = (int'(ptr_i) + k) % Width;
      if (!any_o && req_i[idx]) begin
        any_o        = 1'b1;
        grant_o[idx] = 1'b1;
        bin_grant_o  = SelW'(idx);
      end
    end
  end

endmodule

// File: rtl/axi_b_grant_ctrl.sv
// Per-master B-channel grant controller: holds a grant from selection until
// the B handshake, granting only slaves with outstanding writes from this master.
module axi_b_grant_ctrl
  import axi_ic_pkg::*;
#(
  parameter  int NumSlaves      = 2,
  parameter  int MaxOutstanding = 8,
  localparam int SelW           = sel_width(NumSlaves),
  localparam int CntW           = $clog2(MaxOutstanding + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      aw_done_i,
  input  logic [SelW-1:0]           aw_slave_i,
  output logic                      aw_stall_o,
  input  logic [NumSlaves-1:0]      bvalid_i,
  input  logic                      bready_i,
  output logic                      grant_valid_o,
  output logic [NumSlaves-1:0]      grant_o,
  output logic [SelW-1:0]           bin_grant_o,
  output logic [NumSlaves-1:0]      unexpected_b_o,
  output logic [NumSlaves*CntW-1:0] outstanding_o
);

  localparam logic [0:0]      ST_IDLE = IDLE;
  localparam logic [0:0]      ST_LOCK = LOCK;
  localparam logic [CntW-1:0] CNT_MAX = CntW'(MaxOutstanding);
  localparam logic [CntW-1:0] CNT_ONE = CntW'(1);

  logic [CntW-1:0]      cnt_q [NumSlaves];
  logic [0:0]           state_q;
  logic [NumSlaves-1:0] grant_q;
  logic [SelW-1:0]      g_q;
  logic [SelW-1:0]      ptr_q;
  logic [NumSlaves-1:0] unexp_q;

  logic [NumSlaves-1:0] nonzero, elig, elig_post, inc, dec;
  logic [NumSlaves-1:0] arb_req, pick_grant;
  logic [SelW-1:0]      arb_ptr, pick_bin;
  logic                 pick_any, hs;

  // The held grant is one-hot, so the handshake needs no index decode.
  assign hs = (state_q == ST_LOCK) && |(bvalid_i & grant_q) && bready_i;

  always_comb begin
    nonzero    = '0;
    elig       = '0;
    elig_post  = '0;
    inc        = '0;
    dec        = '0;
    aw_stall_o = 1'b0;
    for (int j = 0; j < NumSlaves; j++) begin
      nonzero[j]   = (cnt_q[j] != '0);
      elig[j]      = bvalid_i[j] && nonzero[j];
      // The slave being retired stays eligible only if it still has writes left.
      elig_post[j] = elig[j] && !(grant_q[j] && cnt_q[j] == CNT_ONE);
      inc[j]       = aw_done_i && (aw_slave_i == SelW'(j)) && (cnt_q[j] != CNT_MAX);
      dec[j]       = hs && grant_q[j];
      if (aw_slave_i == SelW'(j) && cnt_q[j] == CNT_MAX)
        aw_stall_o = 1'b1;
    end
  end

  assign arb_req = hs ? elig_post : elig;
  assign arb_ptr = hs ? g_q : ptr_q;

  rr_pick #(.Width(NumSlaves)) u_rr_pick (
    .req_i       (arb_req),
    .ptr_i       (arb_ptr),
    .grant_o     (pick_grant),
    .bin_grant_o (pick_bin),
    .any_o       (pick_any)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int j = 0; j < NumSlaves; j++) cnt_q[j] <= '0;
    end else begin
      for (int j = 0; j < NumSlaves; j++) begin
        if (inc[j] && !dec[j])
          cnt_q[j] <= cnt_q[j] + CNT_ONE;
        else if (dec[j] && !inc[j])
          cnt_q[j] <= cnt_q[j] - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      g_q     <= '0;
      ptr_q   <= SelW'(NumSlaves - 1);
      unexp_q <= '0;
    end else begin
      unexp_q <= bvalid_i & ~nonzero;
      if (hs)
        ptr_q <= g_q;
      // A held grant is only re-arbitrated on its own handshake.
      if (state_q == ST_IDLE || hs) begin
        if (pick_any) begin
          state_q <= ST_LOCK;
          grant_q <= pick_grant;
          g_q     <= pick_bin;
        end else begin
          state_q <= ST_IDLE;
          grant_q <= '0;
          g_q     <= '0;
        end
      end
    end
  end

  assign grant_valid_o  = (state_q == ST_LOCK);
  assign grant_o        = grant_q;
  assign bin_grant_o    = g_q;
  assign unexpected_b_o = unexp_q;

  for (genvar j = 0; j < NumSlaves; j++) begin : g_pack
    assign outstanding_o[j*CntW +: CntW] = cnt_q[j];
  end

endmodule
